// File: rtl/avalon_mem_pkg.sv
// Shared types and constants for the Avalon-MM slave memory model.
package avalon_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } mem_state_t;

    localparam int WAIT_NONE   = 0;
    localparam int WAIT_FIXED  = 1;
    localparam int WAIT_RANDOM = 2;

    // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/avalon_wait_gen.sv
// Wait-state generator: LFSR plus mode select, producing the extra wait count N
// for the next access. The LFSR steps once per accepted request.
module avalon_wait_gen
    import avalon_mem_pkg::*;
#(
    parameter int          WAIT_MODE  = WAIT_RANDOM,
    parameter int          FIXED_WAIT = 1,
    parameter int          MAX_WAIT   = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] wait_n
);

    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_comb begin
        wait_n = 8'd0;
        case (WAIT_MODE)
            WAIT_FIXED:  wait_n = 8'(FIXED_WAIT);
            WAIT_RANDOM: wait_n = 8'(lfsr % 16'(MAX_WAIT + 1));
            default:     wait_n = 8'd0;
        endcase
    end

endmodule

// File: rtl/avalon_mem_model.sv
// Avalon-MM slave memory with configurable depth, base address and wait states.
// Handshake is driven from registered state; flags are sticky until reset.
//
//   state | meaning
//   IDLE  | no access in flight; a request loads the wait count
//   WAIT  | counting down extra wait cycles, waitrequest held high
//   ACK   | access complete, waitrequest low for exactly one cycle
module avalon_mem_model
    import avalon_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter bit          WRAP_ADDR   = 1'b1,
    parameter int          WAIT_MODE   = WAIT_RANDOM,
    parameter int          FIXED_WAIT  = 1,
    parameter int          MAX_WAIT    = 5,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        addr_err,
    output logic        protocol_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    mem_state_t       state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [7:0]       wait_n;
    logic             req;
    logic             advance;
    logic             commit;
    logic             drop;
    logic [31:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             addr_ok;
    logic             unaligned;
    logic             rd_ok;
    logic             wr_ok;
    logic [31:0]      mem [DEPTH_WORDS];

    avalon_wait_gen #(
        .WAIT_MODE  (WAIT_MODE),
        .FIXED_WAIT (FIXED_WAIT),
        .MAX_WAIT   (MAX_WAIT),
        .LFSR_SEED  (LFSR_SEED)
    ) u_wait_gen (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .wait_n  (wait_n)
    );

    // Subtraction wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign word_off  = (address - BASE_ADDR) >> 2;
    assign idx       = word_off[IDX_W-1:0];
    assign in_range  = word_off < 32'(DEPTH_WORDS);
    assign addr_ok   = WRAP_ADDR || in_range;
    assign unaligned = address[1:0] != 2'b00;

    assign req         = read | write;
    assign rd_ok       = read & ~write;
    assign wr_ok       = write & ~read;
    assign waitrequest = req & (state != ACK);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        advance   = 1'b0;
        commit    = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    advance = 1'b1;
                    cnt_nxt = wait_n;
                    if (wait_n == 8'd0) begin
                        state_nxt = ACK;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                    drop      = 1'b1;
                end else if (cnt <= 8'd1) begin
                    // Last wait cycle: the IDLE cycle already counted as one, total is 1+N.
                    state_nxt = ACK;
                    cnt_nxt   = 8'd0;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Memory lives in the reset block so a write pending at reset is never committed;
    // the array itself is deliberately not cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            readdata     <= 32'h0;
            addr_err     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit && rd_ok) begin
                readdata <= addr_ok ? mem[idx] : 32'h0;
            end
            if (commit && wr_ok && addr_ok) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        mem[idx][8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
            if (state == IDLE && req && (unaligned || !addr_ok)) begin
                addr_err <= 1'b1;
            end
            if ((state == IDLE && read && write) || drop) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_mem_model.sv
// Directed and randomised checks of three memory model configurations:
// no waits, fixed waits with non-wrapping 16-word decode, random waits with 16-word wrap.
module tb_avalon_mem_model;

    localparam logic [31:0] BASE = 32'hBFC00000;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [3:0]  byteenable = 4'h0;
    logic [2:0]  rd_r = 3'b000;
    logic [2:0]  wr_r = 3'b000;
    logic [2:0]  wreq;
    logic [2:0]  aerr;
    logic [2:0]  perr;
    logic [31:0] rdata [3];

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] m_lfsr = SEED;
    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];
    logic [31:0] mem2 [16];
    logic [31:0] last2 = 32'h0;

    always #5 clk = ~clk;

    avalon_mem_model #(.WAIT_MODE(0)) u0 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .read(rd_r[0]), .write(wr_r[0]), .writedata(writedata),
        .waitrequest(wreq[0]), .readdata(rdata[0]), .addr_err(aerr[0]), .protocol_err(perr[0])
    );

    avalon_mem_model #(.WAIT_MODE(1), .FIXED_WAIT(3), .DEPTH_WORDS(16), .WRAP_ADDR(1'b0)) u1 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .read(rd_r[1]), .write(wr_r[1]), .writedata(writedata),
        .waitrequest(wreq[1]), .readdata(rdata[1]), .addr_err(aerr[1]), .protocol_err(perr[1])
    );

    avalon_mem_model #(.WAIT_MODE(2), .MAX_WAIT(5), .DEPTH_WORDS(16), .WRAP_ADDR(1'b1),
                       .LFSR_SEED(SEED)) u2 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .read(rd_r[2]), .write(wr_r[2]), .writedata(writedata),
        .waitrequest(wreq[2]), .readdata(rdata[2]), .addr_err(aerr[2]), .protocol_err(perr[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 16-bit Fibonacci LFSR, taps 16,14,13,11, written as plain shifts and xors.
    function automatic logic [15:0] lfsr_model(input logic [15:0] l);
        int unsigned x, fb;
        x  = l;
        fb = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
        x  = (x >> 1) | (fb << 15);
        return x[15:0];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    // Presents one request at a falling edge and counts cycles with waitrequest high.
    // Returns in the acknowledge cycle with the request still asserted.
    task automatic access(input int u, input bit r_, input bit w_, input logic [31:0] a,
                          input logic [31:0] d_, input logic [3:0] be_,
                          output int wc, output logic [31:0] rv);
        @(negedge clk);
        address    = a;
        writedata  = d_;
        byteenable = be_;
        rd_r[u]    = r_;
        wr_r[u]    = w_;
        #1;
        wc = 0;
        while (wreq[u] === 1'b1 && wc < 300) begin
            wc++;
            @(negedge clk);
            #1;
        end
        rv = rdata[u];
    endtask

    task automatic release_req(input int u);
        rd_r[u] = 1'b0;
        wr_r[u] = 1'b0;
    endtask

    task automatic acc2(input bit r_, input bit w_, input logic [31:0] a, input logic [31:0] d_,
                        input logic [3:0] be_, output int wc, output logic [31:0] rv);
        int exp_n;
        exp_n  = int'(m_lfsr) % 6;
        m_lfsr = lfsr_model(m_lfsr);
        access(2, r_, w_, a, d_, be_, wc, rv);
        release_req(2);
        chk("u2_wait", 32'(wc), 32'(1 + exp_n));
        chk("u2_n_le_max", 32'(wc - 1 <= 5), 32'd1);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        rd_r  = 3'b000;
        wr_r  = 3'b000;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_lfsr = SEED;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          wc;
        int          w;
        int          n_peek;
        logic [31:0] r;
        logic [31:0] dat;
        logic [3:0]  be;
        bit          is_wr;
        int          sw [12];
        logic [31:0] sd [12];
        int          q1 [$];
        int          q2 [$];

        // Reset state, and waitrequest tracking read while reset is held.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wreq", 32'(wreq), 32'd0);
        chk("rst_aerr", 32'(aerr), 32'd0);
        chk("rst_perr", 32'(perr), 32'd0);
        for (int i = 0; i < 3; i++) chk("rst_rdata", rdata[i], 32'h0);
        rd_r[0] = 1'b1;
        #1;
        chk("rst_wreq_follows_read", 32'(wreq[0]), 32'd1);
        rd_r[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // No wait states: one waitrequest cycle per access.
        access(0, 1'b0, 1'b1, BASE, 32'h12345678, 4'hF, wc, r);
        release_req(0);
        chk("u0_wr_wait", 32'(wc), 32'd1);
        access(0, 1'b1, 1'b0, BASE, 32'h0, 4'hF, wc, r);
        release_req(0);
        chk("u0_rd_wait", 32'(wc), 32'd1);
        chk("u0_rd_data", r, 32'h12345678);
        for (int i = 0; i < 16; i++) begin
            mem0[i] = $urandom;
            access(0, 1'b0, 1'b1, BASE + 32'(4 * i), mem0[i], 4'hF, wc, r);
            release_req(0);
        end
        for (int i = 0; i < 16; i++) begin
            w = (i * 7) % 16;
            access(0, 1'b1, 1'b0, BASE + 32'(4 * w), 32'h0, 4'hF, wc, r);
            release_req(0);
            chk("u0_rand_wait", 32'(wc), 32'd1);
            chk("u0_rand_data", r, mem0[w]);
        end

        // Fixed three extra waits, including a back-to-back read.
        mem1[1] = 32'hC0DE0001;
        access(1, 1'b0, 1'b1, BASE + 32'h4, mem1[1], 4'hF, wc, r);
        release_req(1);
        chk("u1_wr_wait", 32'(wc), 32'd4);
        access(1, 1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'hF, wc, r);
        chk("u1_rd_wait", 32'(wc), 32'd4);
        chk("u1_rd_data", r, mem1[1]);
        access(1, 1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'hF, wc, r);
        release_req(1);
        chk("u1_b2b_wait", 32'(wc), 32'd4);
        chk("u1_b2b_data", r, mem1[1]);

        // Random waits: fill all words, then byte lanes, then random traffic.
        for (int i = 0; i < 16; i++) begin
            mem2[i] = $urandom;
            acc2(1'b0, 1'b1, BASE + 32'(4 * i), mem2[i], 4'hF, wc, r);
        end
        acc2(1'b0, 1'b1, BASE + 32'h8, 32'hAABBCCDD, 4'hF, wc, r);
        acc2(1'b0, 1'b1, BASE + 32'h8, 32'h11223344, 4'b0101, wc, r);
        acc2(1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'hF, wc, r);
        chk("u2_byte_lanes", r, 32'hAA22CC44);
        acc2(1'b0, 1'b1, BASE + 32'h8, 32'h55555555, 4'b0000, wc, r);
        acc2(1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'hF, wc, r);
        chk("u2_be_zero", r, 32'hAA22CC44);
        mem2[2] = 32'hAA22CC44;
        for (int i = 0; i < 40; i++) begin
            w     = $urandom_range(15);
            is_wr = 1'($urandom_range(1));
            dat   = $urandom;
            be    = 4'($urandom_range(15));
            acc2(!is_wr, is_wr, BASE + 32'(4 * w), dat, be, wc, r);
            if (is_wr) begin
                mem2[w] = merge(mem2[w], dat, be);
            end else begin
                chk("u2_rand_data", r, mem2[w]);
            end
        end
        acc2(1'b1, 1'b0, BASE, 32'h0, 4'hF, wc, r);
        chk("u2_word0", r, mem2[0]);

        // Out-of-range without wrap, then aliasing and unaligned with wrap.
        mem1[0] = 32'h0000F00D;
        access(1, 1'b0, 1'b1, BASE, mem1[0], 4'hF, wc, r);
        release_req(1);
        chk("u1_aerr_before", 32'(aerr[1]), 32'd0);
        access(1, 1'b0, 1'b1, BASE + 32'h40, 32'hDEADDEAD, 4'hF, wc, r);
        release_req(1);
        chk("u1_oor_wr_wait", 32'(wc), 32'd4);
        chk("u1_oor_aerr", 32'(aerr[1]), 32'd1);
        access(1, 1'b1, 1'b0, BASE + 32'h40, 32'h0, 4'hF, wc, r);
        release_req(1);
        chk("u1_oor_rd_wait", 32'(wc), 32'd4);
        chk("u1_oor_rd_zero", r, 32'h0);
        access(1, 1'b1, 1'b0, BASE, 32'h0, 4'hF, wc, r);
        release_req(1);
        chk("u1_word0_kept", r, mem1[0]);

        acc2(1'b0, 1'b1, BASE + 32'h40, 32'h0A11A500, 4'hF, wc, r);
        mem2[0] = 32'h0A11A500;
        acc2(1'b1, 1'b0, BASE, 32'h0, 4'hF, wc, r);
        chk("u2_alias_word0", r, mem2[0]);
        chk("u2_aerr_aligned", 32'(aerr[2]), 32'd0);
        acc2(1'b0, 1'b1, BASE + 32'h7, 32'h07070707, 4'hF, wc, r);
        mem2[1] = 32'h07070707;
        chk("u2_unaligned_aerr", 32'(aerr[2]), 32'd1);
        acc2(1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'hF, wc, r);
        chk("u2_unaligned_data", r, mem2[1]);
        last2 = r;

        // Read and write together, then a write dropped during its wait.
        chk("u2_perr_before", 32'(perr[2]), 32'd0);
        acc2(1'b1, 1'b1, BASE + 32'hC, 32'hBADBAD00, 4'hF, wc, r);
        chk("u2_rw_perr", 32'(perr[2]), 32'd1);
        chk("u2_rw_rdata_held", r, last2);
        acc2(1'b1, 1'b0, BASE + 32'hC, 32'h0, 4'hF, wc, r);
        chk("u2_rw_mem_kept", r, mem2[3]);

        chk("u1_perr_before", 32'(perr[1]), 32'd0);
        @(negedge clk);
        address    = BASE + 32'h4;
        writedata  = 32'h0BAD0BAD;
        byteenable = 4'hF;
        wr_r[1]    = 1'b1;
        #1;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("u1_wreq_in_wait", 32'(wreq[1]), 32'd1);
        wr_r[1] = 1'b0;
        #1;
        chk("u1_wreq_dropped", 32'(wreq[1]), 32'd0);
        @(negedge clk);
        #1;
        chk("u1_drop_perr", 32'(perr[1]), 32'd1);
        access(1, 1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'hF, wc, r);
        release_req(1);
        chk("u1_drop_no_commit", r, mem1[1]);

        // Reset in the middle of a write: no commit, flags and readdata cleared.
        n_peek = int'(m_lfsr) % 6;
        @(negedge clk);
        address    = BASE + 32'h14;
        writedata  = 32'hDEADBEEF;
        byteenable = 4'hF;
        wr_r[2]    = 1'b1;
        #1;
        if (n_peek >= 1) begin
            @(negedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("rst_mid_wreq", 32'(wreq[2]), 32'd1);
        chk("rst_mid_aerr", 32'(aerr), 32'd0);
        chk("rst_mid_perr", 32'(perr), 32'd0);
        chk("rst_mid_rdata", rdata[2], 32'h0);
        wr_r[2] = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_lfsr = SEED;
        acc2(1'b1, 1'b0, BASE + 32'h14, 32'h0, 4'hF, wc, r);
        chk("rst_mid_word_kept", r, mem2[5]);

        // Same traffic after two resets must see the same wait sequence.
        for (int i = 0; i < 12; i++) begin
            sw[i] = $urandom_range(15);
            sd[i] = $urandom;
        end
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                acc2(1'b0, 1'b1, BASE + 32'(4 * sw[i]), sd[i], 4'hF, wc, r);
                mem2[sw[i]] = sd[i];
            end else begin
                acc2(1'b1, 1'b0, BASE + 32'(4 * sw[i]), 32'h0, 4'hF, wc, r);
                chk("seq1_data", r, mem2[sw[i]]);
            end
            q1.push_back(wc);
        end
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                acc2(1'b0, 1'b1, BASE + 32'(4 * sw[i]), sd[i], 4'hF, wc, r);
                mem2[sw[i]] = sd[i];
            end else begin
                acc2(1'b1, 1'b0, BASE + 32'(4 * sw[i]), 32'h0, 4'hF, wc, r);
                chk("seq2_data", r, mem2[sw[i]]);
            end
            q2.push_back(wc);
        end
        for (int i = 0; i < 12; i++) chk("seq_repeat", 32'(q2[i]), 32'(q1[i]));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
